// File: rtl/adder_arbiter.sv
// rtl/adder_arbiter.sv - round-robin arbiter sharing one cla_32 adder across requesters.
// Optional macro ADDER_SUB_EN adds per-requester req_sub (a - b via ~b and forced carry-in).

module cla_32 (
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic        cin_i,
    output logic [31:0] sum_o,
    output logic        cout_o
);

    logic [31:0] bit_g;
    logic [31:0] bit_p;
    logic [31:0] carry;
    logic [7:0]  grp_g;
    logic [7:0]  grp_p;
    logic [8:0]  grp_c;

    // Carries into each bit of a 4-bit group, fully expanded from the group carry-in.
    function automatic logic [3:0] carries4(input logic [3:0] g, input logic [3:0] p,
                                            input logic c0);
        logic [3:0] c;
        c[0] = c0;
        c[1] = g[0] | (p[0] & c0);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
        return c;
    endfunction

    function automatic logic grp_generate(input logic [3:0] g, input logic [3:0] p);
        return g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    endfunction

    function automatic logic [8:0] group_carries(input logic [7:0] gg, input logic [7:0] gp,
                                                 input logic c0);
        logic [8:0] c;
        c[0] = c0;
        for (int k = 0; k < 8; k++) begin
            c[k+1] = gg[k] | (gp[k] & c[k]);
        end
        return c;
    endfunction

    assign bit_g = a_i & b_i;
    assign bit_p = a_i ^ b_i;

    for (genvar gi = 0; gi < 8; gi++) begin : g_grp
        assign grp_g[gi]        = grp_generate(bit_g[4*gi +: 4], bit_p[4*gi +: 4]);
        assign grp_p[gi]        = &bit_p[4*gi +: 4];
        assign carry[4*gi +: 4] = carries4(bit_g[4*gi +: 4], bit_p[4*gi +: 4], grp_c[gi]);
    end

    assign grp_c  = group_carries(grp_g, grp_p, cin_i);
    assign sum_o  = bit_p ^ carry;
    assign cout_o = grp_c[8];

endmodule

module adder_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int ID_W    = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [NUM_REQ*32-1:0] req_a,
    input  logic [NUM_REQ*32-1:0] req_b,
    input  logic [NUM_REQ-1:0]   req_cin,
`ifdef ADDER_SUB_EN
    input  logic [NUM_REQ-1:0]   req_sub,
`endif
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [ID_W-1:0]      rsp_id,
    output logic [31:0]          rsp_sum,
    output logic                 rsp_cout,
    output logic                 rsp_ovf
);

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } rsp_state_e;

    rsp_state_e      state_q;
    logic [ID_W-1:0] ptr_q;
    logic [ID_W-1:0] ptr_d;
    logic [ID_W-1:0] rsp_id_q;
    logic [31:0]     rsp_sum_q;
    logic            rsp_cout_q;
    logic            rsp_ovf_q;

    logic            gnt_vld;
    logic [ID_W-1:0] gnt_idx;
    logic            slot_free;
    logic            accept;
    logic [31:0]     a_sel;
    logic [31:0]     b_sel;
    logic            cin_sel;
    logic            sub_sel;
    logic [31:0]     b_eff;
    logic            cin_eff;
    logic [31:0]     sum;
    logic            cout;
    logic            ovf;

    function automatic logic [ID_W-1:0] wrap_idx(input logic [ID_W-1:0] base,
                                                 input int unsigned k);
        int unsigned s;
        s = 32'(base) + k;
        if (s >= 32'(NUM_REQ)) begin
            s = s - 32'(NUM_REQ);
        end
        return s[ID_W-1:0];
    endfunction

    // Walk downward so the requester closest to ptr (lowest offset) wins.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = ptr_q;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_valid[wrap_idx(ptr_q, k)]) begin
                gnt_vld = 1'b1;
                gnt_idx = wrap_idx(ptr_q, k);
            end
        end
    end

    assign slot_free = (state_q == S_EMPTY) || rsp_ready;
    assign accept    = gnt_vld && slot_free && !rst;
    assign req_ready = accept ? (NUM_REQ'(1) << gnt_idx) : '0;
    assign ptr_d     = accept ? wrap_idx(gnt_idx, 1) : ptr_q;

    always_comb begin
        a_sel   = '0;
        b_sel   = '0;
        cin_sel = 1'b0;
        sub_sel = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_idx == ID_W'(i)) begin
                a_sel   = req_a[32*i +: 32];
                b_sel   = req_b[32*i +: 32];
                cin_sel = req_cin[i];
`ifdef ADDER_SUB_EN
                sub_sel = req_sub[i];
`endif
            end
        end
    end

    assign b_eff   = sub_sel ? ~b_sel : b_sel;
    assign cin_eff = sub_sel ? 1'b1 : cin_sel;

    cla_32 u_cla (
        .a_i    (a_sel),
        .b_i    (b_eff),
        .cin_i  (cin_eff),
        .sum_o  (sum),
        .cout_o (cout)
    );

    assign ovf = (a_sel[31] == b_eff[31]) && (sum[31] != a_sel[31]);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_EMPTY;
            ptr_q      <= '0;
            rsp_id_q   <= '0;
            rsp_sum_q  <= '0;
            rsp_cout_q <= 1'b0;
            rsp_ovf_q  <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
            if (accept) begin
                rsp_id_q   <= gnt_idx;
                rsp_sum_q  <= sum;
                rsp_cout_q <= cout;
                rsp_ovf_q  <= ovf;
            end
            case (state_q)
                S_EMPTY: if (accept) state_q <= S_FULL;
                S_FULL:  if (!accept && rsp_ready) state_q <= S_EMPTY;
            endcase
        end
    end

    assign rsp_valid = (state_q == S_FULL);
    assign rsp_id    = rsp_id_q;
    assign rsp_sum   = rsp_sum_q;
    assign rsp_cout  = rsp_cout_q;
    assign rsp_ovf   = rsp_ovf_q;

endmodule

// File: tb/tb_adder_arbiter.sv
// tb/tb_adder_arbiter.sv - directed self-checking bench for adder_arbiter.

module tb_adder_arbiter;

    localparam int NUM_REQ = 3;
    localparam int ID_W    = 2;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ*32-1:0] req_a;
    logic [NUM_REQ*32-1:0] req_b;
    logic [NUM_REQ-1:0]    req_cin;
`ifdef ADDER_SUB_EN
    logic [NUM_REQ-1:0]    req_sub;
`endif
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [ID_W-1:0]       rsp_id;
    logic [31:0]           rsp_sum;
    logic                  rsp_cout;
    logic                  rsp_ovf;

    int checks = 0;
    int errors = 0;

    adder_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_cin   (req_cin),
`ifdef ADDER_SUB_EN
        .req_sub   (req_sub),
`endif
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout),
        .rsp_ovf   (rsp_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b,
                          input logic cin);
        req_a[32*i +: 32] = a;
        req_b[32*i +: 32] = b;
        req_cin[i]        = cin;
    endtask

    task automatic chk_rsp(input string tag, input logic [31:0] id, input logic [31:0] sum,
                           input logic [31:0] cout, input logic [31:0] ovf);
        chk({tag, "_valid"}, 32'(rsp_valid), 32'd1);
        chk({tag, "_id"}, 32'(rsp_id), id);
        chk({tag, "_sum"}, rsp_sum, sum);
        chk({tag, "_cout"}, 32'(rsp_cout), cout);
        chk({tag, "_ovf"}, 32'(rsp_ovf), ovf);
    endtask

    int          rr_idx [5] = '{0, 1, 2, 0, 1};
    logic [31:0] rr_sum [3] = '{32'h0000_0101, 32'h0000_0203, 32'h0000_0000};
    logic        rr_cout[3] = '{1'b0, 1'b0, 1'b1};
    logic        rr_ovf [3] = '{1'b0, 1'b0, 1'b1};

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_cin   = '0;
        rsp_ready = 1'b0;
`ifdef ADDER_SUB_EN
        req_sub   = '0;
`endif
        tick();

        // Fill the response slot, then reset on top of it with all requesters valid.
        rst = 1'b0;
        set_op(0, 32'd1, 32'd2, 1'b0);
        req_valid = 3'b001;
        tick();
        chk_rsp("pre_reset", 32'd0, 32'd3, 32'd0, 32'd0);
        rst       = 1'b1;
        req_valid = 3'b111;
        #1;
        chk("ready_in_reset", 32'(req_ready), 32'd0);
        tick();
        chk("rst_valid", 32'(rsp_valid), 32'd0);
        chk("rst_id", 32'(rsp_id), 32'd0);
        chk("rst_sum", rsp_sum, 32'd0);
        chk("rst_cout", 32'(rsp_cout), 32'd0);
        chk("rst_ovf", 32'(rsp_ovf), 32'd0);
        chk("ready_in_reset2", 32'(req_ready), 32'd0);
        tick();
        rst       = 1'b0;
        rsp_ready = 1'b1;
        #1;
        chk("first_grant", 32'(req_ready), 32'b001);
        req_valid = '0;
        #1;
        chk("idle_ready", 32'(req_ready), 32'd0);
        tick();
        chk("idle_valid", 32'(rsp_valid), 32'd0);

        // Wrap-around add on requester 1.
        set_op(1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        req_valid = 3'b010;
        #1;
        chk("single_ready", 32'(req_ready), 32'b010);
        tick();
        chk_rsp("single", 32'd1, 32'h0000_0000, 32'd1, 32'd0);

        // Signed overflow on requester 0; search wraps from ptr=2 to 0.
        set_op(0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
        req_valid = 3'b001;
        #1;
        chk("ovf_ready", 32'(req_ready), 32'b001);
        tick();
        chk_rsp("ovf", 32'd0, 32'h8000_0000, 32'd0, 32'd1);

        req_valid = '0;
        tick();
        chk("drain_valid", 32'(rsp_valid), 32'd0);
        chk("drain_hold_sum", rsp_sum, 32'h8000_0000);

        // Requester 2 alone brings ptr back to 0; cin=1 is added in.
        set_op(2, 32'd10, 32'd20, 1'b1);
        req_valid = 3'b100;
        #1;
        chk("r2_ready", 32'(req_ready), 32'b100);
        tick();
        chk_rsp("r2", 32'd2, 32'd31, 32'd0, 32'd0);

        // Round-robin with all requesters held valid, back-to-back.
        set_op(0, 32'h0000_0100, 32'h0000_0001, 1'b0);
        set_op(1, 32'h0000_0200, 32'h0000_0002, 1'b1);
        set_op(2, 32'h8000_0000, 32'h8000_0000, 1'b0);
        req_valid = 3'b111;
        for (int s = 0; s < 5; s++) begin
            #1;
            chk($sformatf("rr%0d_ready", s), 32'(req_ready), 32'(1) << rr_idx[s]);
            tick();
            chk_rsp($sformatf("rr%0d", s), 32'(rr_idx[s]), rr_sum[rr_idx[s]],
                    32'(rr_cout[rr_idx[s]]), 32'(rr_ovf[rr_idx[s]]));
        end

        // Backpressure: response and grants frozen for 4 cycles.
        rsp_ready = 1'b0;
        for (int s = 0; s < 4; s++) begin
            #1;
            chk($sformatf("bp%0d_ready", s), 32'(req_ready), 32'd0);
            tick();
            chk_rsp($sformatf("bp%0d", s), 32'd1, 32'h0000_0203, 32'd0, 32'd0);
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp_release_ready", 32'(req_ready), 32'b100);
        tick();
        chk_rsp("bp_release", 32'd2, 32'h0000_0000, 32'd1, 32'd1);
        req_valid = '0;
        tick();
        chk("final_drain", 32'(rsp_valid), 32'd0);

`ifdef ADDER_SUB_EN
        set_op(0, 32'h0000_0005, 32'h0000_0007, 1'b0);
        req_sub   = 3'b001;
        req_valid = 3'b001;
        #1;
        chk("sub_ready", 32'(req_ready), 32'b001);
        tick();
        chk_rsp("sub", 32'd0, 32'hFFFF_FFFE, 32'd0, 32'd0);
        req_valid = '0;
        req_sub   = '0;
        tick();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
